orao_tape_rec: RTL and testbench
================================

ORAO_TAPE_REC -- requirements
Module: orao_tape_rec

Interface
REQ-001 SHALL have parameter SHORT_MAX, default 16'd400, the longest half-cycle in ce ticks still classed "short".
REQ-002 SHALL have parameter TIMEOUT, default 16'd20000, the ce ticks without an edge that end a block.
REQ-003 SHALL have port clk, input, 1, system clock; the only clock in the block.
REQ-004 SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port ce, input, 1, 1 MHz timing enable, one clk wide.
REQ-006 SHALL have port tape_out, input, 1, cassette output bit from orao_hw, synchronous to clk.
REQ-007 SHALL have port byte_dout, output, 8, FIFO head byte.
REQ-008 SHALL have port byte_valid, output, 1, FIFO not empty.
REQ-009 SHALL have port byte_ready, input, 1, consumer accepts head when byte_valid is high.
REQ-010 SHALL have port busy, output, 1, high when the state is not IDLE.
REQ-011 SHALL have port eob, output, 1, one-clk end-of-block pulse.
REQ-012 SHALL have port overflow, output, 1, sticky flag: a byte was dropped.
REQ-013 SHALL have port byte_count, output, 16, bytes pushed since reset, wrapping at 16'hFFFF->0.

Function
REQ-014 SHALL register tape_out once and define an edge as any change between the registered value and its previous value.
REQ-015 SHALL use a 16-bit interval counter that increments on ce, saturates at 16'hFFFF, and clears on every edge.
REQ-016 SHALL classify each interval at an edge as short (counter <= SHORT_MAX) or long (counter > SHORT_MAX).
REQ-017 SHALL run an FSM with three states: IDLE, SYNC and DATA.
REQ-018 SHALL in IDLE, on the first edge: move to SYNC, clear the counter, and leave the bit accumulator cleared.
REQ-019 SHALL in SYNC, on a long interval: move to DATA and decode that interval as its first bit; on a short interval: stay in SYNC.
REQ-020 SHALL in DATA: decode one long interval as bit 0; decode two consecutive short intervals as bit 1; on a long interval after a single short one, discard the pending short and decode the long as bit 0.
REQ-021 SHALL shift bits into the byte LSB first and push the byte into the FIFO on the clk after the 8th bit.
REQ-022 SHALL in SYNC or DATA, when counter == TIMEOUT on a ce: return to IDLE, pulse eob for one clk, and discard any partial byte and pending short.
REQ-023 SHALL provide a 16-entry FIFO; byte_dout shall be valid from the same clk that byte_valid is high; a pop occurs on byte_valid & byte_ready.
REQ-024 SHALL on a push into a full FIFO without a simultaneous pop: drop the byte, set overflow, and leave byte_count unchanged.
REQ-025 SHALL on a push and a pop in the same clk, including when full: accept both and leave the occupancy unchanged.
REQ-026 SHALL ignore a pop while empty, with no pointer change.
REQ-027 SHALL increment byte_count only on accepted pushes.

Reset
REQ-028 SHALL, with reset_n low at a clk edge: set state=IDLE, counter=0, accumulator=0, FIFO empty, byte_valid=0, byte_dout=8'h00, busy=0, eob=0, overflow=0, byte_count=0.
REQ-029 SHALL, on a reset mid-block, discard the partial byte and FIFO contents, and emit no eob.
REQ-030 SHALL load the tape_out history register with the current tape_out value during reset, so no edge is detected on release.

Configuration
REQ-031 SHALL use macro ORAO_TAPE_LEADER_STRIP_EN.
REQ-032 SHALL, when ORAO_TAPE_LEADER_STRIP_EN is defined, not push decoded 8'h00 bytes in a block until the first non-zero byte has been pushed; these suppressed bytes shall not count in byte_count.
REQ-033 SHALL, when ORAO_TAPE_LEADER_STRIP_EN is undefined, push every decoded byte including leader zeros.

Verification
REQ-034 SHALL cover: ce every 50 clk; edge, long interval (600 ticks) as sync, then intervals for 8'hA5 LSB first -> byte_dout=8'hA5, byte_valid=1, byte_count=1.
REQ-035 SHALL cover: no edge for 20000 ce after the last bit -> one eob pulse, busy=0, state IDLE.
REQ-036 SHALL cover: byte_ready=0, 17 bytes decoded -> 16 held, overflow=1, byte_count=16; then drain -> bytes in order, byte_valid=0 after the 16th.
REQ-037 SHALL cover: FIFO full with byte_ready=1 held on the clk of the 17th push -> no overflow, byte_count=17.
REQ-038 SHALL cover: reset_n low after 5 bits of a byte -> all outputs at reset values; the next block decodes correctly.
REQ-039 SHALL cover: stream 00 00 00 3C 00 -> with the macro defined, 3C 00 with byte_count=2; with it undefined, 00 00 00 3C 00 with byte_count=5.

Source files
------------

// File: rtl/orao_tape_rec.sv
// orao_tape_rec: Orao cassette bit/byte decoder feeding a 16-entry FIFO.
// Optional leader-zero stripping: define ORAO_TAPE_LEADER_STRIP_EN.
module orao_tape_rec #(
  parameter logic [15:0] SHORT_MAX = 16'd400,
  parameter logic [15:0] TIMEOUT   = 16'd20000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce,
  input  logic        tape_out,
  output logic [7:0]  byte_dout,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        busy,
  output logic        eob,
  output logic        overflow,
  output logic [15:0] byte_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SYNC = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  logic        tape_q;
  logic        tape_prev;
  logic        edge_det;
  logic [15:0] cnt;
  logic        is_short;
  logic        tmo;
  logic [1:0]  state;
  logic [7:0]  acc;
  logic [7:0]  acc_nxt;
  logic [2:0]  nbits;
  logic        pend;
  logic        bit_en;
  logic        bit_val;
  logic        push_req;
  logic [7:0]  push_byte;
  logic        push_go;
  logic        push_acc;
  logic        pop;
  logic        full;
  logic        empty;
  logic [7:0]  mem [16];
  logic [3:0]  wptr;
  logic [3:0]  rptr;
  logic [4:0]  occ;

  // Register tape_out and keep one sample of history for edge detection.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tape_q    <= tape_out;
      tape_prev <= tape_out;
    end else begin
      tape_q    <= tape_q ^ (tape_q ^ tape_out);
      tape_prev <= tape_q;
    end
  end

  assign edge_det = tape_q ^ tape_prev;

  // Half-cycle timer in ce ticks; restarts on every edge, saturates.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (edge_det) begin
      cnt <= '0;
    end else if (ce && (cnt != 16'hFFFF)) begin
      cnt <= cnt + 16'd1;
    end
  end

  assign is_short = (cnt <= SHORT_MAX);
  assign tmo      = ce && (cnt == TIMEOUT) && (state != S_IDLE);
  assign busy     = (state != S_IDLE);

  // Bit decode: long -> 0, short+short -> 1; a lone short is dropped.
  always_comb begin
    bit_en  = 1'b0;
    bit_val = 1'b0;
    if (edge_det && !tmo) begin
      unique case (1'b1)
        (state == S_SYNC): bit_en = !is_short;
        (state == S_DATA): begin
          bit_en  = !is_short || pend;
          bit_val = is_short && pend;
        end
        default: bit_en = 1'b0;
      endcase
    end
  end

  assign acc_nxt = {bit_val, acc[7:1]};

  // Block FSM, LSB-first byte assembly and end-of-block detection.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      acc       <= '0;
      nbits     <= '0;
      pend      <= 1'b0;
      eob       <= 1'b0;
      push_req  <= 1'b0;
      push_byte <= '0;
    end else begin
      eob      <= 1'b0;
      push_req <= 1'b0;
      if (tmo) begin
        state <= S_IDLE;
        eob   <= 1'b1;
        acc   <= '0;
        nbits <= '0;
        pend  <= 1'b0;
      end else if (edge_det) begin
        case (state)
          S_IDLE: begin
            state <= S_SYNC;
            acc   <= '0;
            nbits <= '0;
            pend  <= 1'b0;
          end
          S_SYNC: begin
            if (!is_short) state <= S_DATA;
          end
          S_DATA: pend <= is_short && !pend;
          default: state <= S_IDLE;
        endcase
        if (bit_en) begin
          acc   <= acc_nxt;
          nbits <= nbits + 3'd1;
          if (nbits == 3'd7) begin
            push_req  <= 1'b1;
            push_byte <= acc_nxt;
          end
        end
      end
    end
  end

`ifdef ORAO_TAPE_LEADER_STRIP_EN
  logic lead_done;

  // Track whether this block has produced a non-zero byte yet.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lead_done <= 1'b0;
    end else if (push_req && (push_byte != 8'h00)) begin
      lead_done <= 1'b1;
    end else if (state == S_IDLE) begin
      lead_done <= 1'b0;
    end
  end

  assign push_go = push_req && (lead_done || (push_byte != 8'h00));
`else
  assign push_go = push_req;
`endif

  assign empty      = (occ == 5'd0);
  assign full       = occ[4];
  assign byte_valid = !empty;
  assign byte_dout  = empty ? 8'h00 : mem[rptr];
  assign pop        = byte_valid && byte_ready;
  assign push_acc   = push_go && (!full || pop);

  // FIFO storage; contents are masked while empty.
  always_ff @(posedge clk) begin
    if (reset_n && push_acc) mem[wptr] <= push_byte;
  end

  // FIFO pointers, occupancy, overflow flag and push counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wptr       <= '0;
      rptr       <= '0;
      occ        <= '0;
      overflow   <= 1'b0;
      byte_count <= '0;
    end else begin
      if (push_acc) begin
        wptr       <= wptr + 4'd1;
        byte_count <= byte_count + 16'd1;
      end
      if (pop) rptr <= rptr + 4'd1;
      unique case ({push_acc, pop})
        2'b10:   occ <= occ + 5'd1;
        2'b01:   occ <= occ - 5'd1;
        default: occ <= occ;
      endcase
      if (push_go && !push_acc) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_orao_tape_rec.sv
// tb_orao_tape_rec: scoreboard bench for the tape decoder.
// Shortened timing parameters keep the run small.
module tb_orao_tape_rec;

  localparam int CE_DIV = 5;
  localparam int T_S    = 3;
  localparam int T_L    = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce = 1'b0;
  logic        tape_out = 1'b0;
  logic        byte_ready = 1'b0;
  logic [7:0]  byte_dout;
  logic        byte_valid;
  logic        busy;
  logic        eob;
  logic        overflow;
  logic [15:0] byte_count;

  int vectors = 0;
  int errors = 0;
  int eob_cnt = 0;
  logic [7:0] exp_q [$];
  logic [7:0] exp_b;
  logic [7:0] blk [17];

  orao_tape_rec #(
    .SHORT_MAX(16'd4),
    .TIMEOUT(16'd20)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .ce(ce),
    .tape_out(tape_out),
    .byte_dout(byte_dout),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .busy(busy),
    .eob(eob),
    .overflow(overflow),
    .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (CE_DIV - 1) @(posedge clk);
      #1 ce = 1'b1;
      @(posedge clk);
      #1 ce = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted pop is compared with the scoreboard head.
  always @(negedge clk) begin
    if (eob) eob_cnt++;
    if (reset_n && byte_valid && byte_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL pop_extra: got %0h expected none", byte_dout);
      end else begin
        exp_b = exp_q.pop_front();
        check("pop_byte", 32'(byte_dout), 32'(exp_b));
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_ce(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (!ce) @(posedge clk);
    end
  endtask

  task automatic interval(input int n);
    wait_ce(n);
    #1 tape_out = ~tape_out;
  endtask

  task automatic send_bit(input logic b);
    if (b) begin
      interval(T_S);
      interval(T_S);
    end else begin
      interval(T_L);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int nb);
    for (int k = 0; k < nb; k++) send_bit(b[k]);
  endtask

  task automatic start_block();
    wait_ce(4);
    #1 tape_out = ~tape_out;
    interval(T_S);
    interval(T_S);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset_n = 1'b0;
    byte_ready = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic wait_eob(input string tag);
    int e0;
    int k;
    e0 = eob_cnt;
    k = 0;
    while (busy && (k < 200 * CE_DIV)) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_eob"}, 32'(eob_cnt - e0), 32'd1);
  endtask

  task automatic drain(input string tag);
    @(posedge clk);
    #1 byte_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!byte_valid) break;
    end
    @(posedge clk);
    #1 byte_ready = 1'b0;
    check({tag, "_valid"}, 32'(byte_valid), 32'd0);
    check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_dout"}, 32'(byte_dout), 32'd0);
  endtask

  initial begin
    logic [7:0] v;
    int e0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(byte_valid), 32'd0);
    check("rst_dout", 32'(byte_dout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_eob", 32'(eob), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_cnt", 32'(byte_count), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Two bytes (second has a stray short before a long) and a
    // trailing partial byte that the timeout must throw away.
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'hA5);
    start_block();
    send_byte(8'h5A, 8);
    v = 8'hA5;
    send_bit(v[0]);
    interval(T_S);
    interval(T_L);
    for (int k = 2; k < 8; k++) send_bit(v[k]);
    send_bit(1'b0);
    send_bit(1'b0);
    interval(T_S);
    wait_eob("blk1");
    check("blk1_cnt", 32'(byte_count), 32'd2);
    check("blk1_valid", 32'(byte_valid), 32'd1);
    check("blk1_head", 32'(byte_dout), 32'h5A);

    exp_q.push_back(8'h3C);
    start_block();
    send_byte(8'h3C, 8);
    wait_eob("blk2");
    check("blk2_cnt", 32'(byte_count), 32'd3);
    drain("d1");

    // 17 bytes with no consumer: 16 kept, the last one dropped.
    do_reset();
    for (int i = 0; i < 17; i++) blk[i] = 8'h02 + 8'(i * 17);
    for (int i = 0; i < 16; i++) exp_q.push_back(blk[i]);
    start_block();
    for (int i = 0; i < 17; i++) send_byte(blk[i], 8);
    wait_eob("ovf");
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_cnt", 32'(byte_count), 32'd16);
    check("ovf_valid", 32'(byte_valid), 32'd1);
    drain("d2");
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Full FIFO, pop coinciding with the 17th push.
    do_reset();
    for (int i = 0; i < 17; i++) exp_q.push_back(blk[i]);
    start_block();
    for (int i = 0; i < 16; i++) send_byte(blk[i], 8);
    v = blk[16];
    send_byte(v, 7);
    if (v[7]) begin
      interval(T_S);
      wait_ce(T_S);
    end else begin
      wait_ce(T_L);
    end
    #1 tape_out = ~tape_out;
    @(posedge clk);
    @(posedge clk);
    #1 byte_ready = 1'b1;
    @(posedge clk);
    #1 byte_ready = 1'b0;
    repeat (4) @(negedge clk);
    check("full_pp_ovf", 32'(overflow), 32'd0);
    check("full_pp_cnt", 32'(byte_count), 32'd17);
    wait_eob("fpp");
    drain("d3");

    // Reset in the middle of a byte, then a clean block.
    do_reset();
    exp_q.push_back(8'h5A);
    start_block();
    send_byte(8'h5A, 8);
    send_byte(8'h3C, 5);
    repeat (4) @(negedge clk);
    check("mid_valid", 32'(byte_valid), 32'd1);
    @(posedge clk);
    #1 reset_n = 1'b0;
    e0 = eob_cnt;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_valid", 32'(byte_valid), 32'd0);
    check("mid_rst_dout", 32'(byte_dout), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_cnt", 32'(byte_count), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("mid_no_eob", 32'(eob_cnt - e0), 32'd0);
    check("mid_idle", 32'(busy), 32'd0);
    exp_q.push_back(8'h3C);
    start_block();
    send_byte(8'h3C, 8);
    wait_eob("mid2");
    check("mid2_cnt", 32'(byte_count), 32'd1);
    drain("d4");

    // Leader zeros ahead of real data.
    do_reset();
`ifdef ORAO_TAPE_LEADER_STRIP_EN
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'h00);
`else
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'h00);
`endif
    start_block();
    send_byte(8'h00, 8);
    send_byte(8'h00, 8);
    send_byte(8'h00, 8);
    send_byte(8'h3C, 8);
    send_byte(8'h00, 8);
    wait_eob("lead");
`ifdef ORAO_TAPE_LEADER_STRIP_EN
    check("lead_cnt", 32'(byte_count), 32'd2);
`else
    check("lead_cnt", 32'(byte_count), 32'd5);
`endif
    drain("d5");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
